contador_flancos_param: RTL and testbench
=========================================

Name: contador_flancos_param

Overview:
Parametrised edge counter, successor to the single-width rising-edge counter. Synchronises an asynchronous event input and counts qualified edges: rising, falling, both or none. Supports up/down counting, load, clear, wrap or saturate at a programmable maximum, and status flags. Used wherever an event or pulse count feeds control logic or a display.

Parameters:
WIDTH, 8, counter width in bits.
SYNC_STAGES, 2, synchroniser flops on en_i (minimum 2).
MAX_VAL, 2**WIDTH-1, top of count range (0..MAX_VAL); must be at most 2**WIDTH-1.
SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.
DEB_CYCLES, 4, debounce stability length; used only with the optional feature.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_i  input  1  synchronous reset, active-high.
en_i  input  1  asynchronous event input.
edge_sel_i  input  2  edge mode: 00 rising, 01 falling, 10 both, 11 disabled.
up_i  input  1  1 = increment, 0 = decrement.
clr_i  input  1  synchronous clear of count and overflow flag.
load_i  input  1  synchronous load of load_val_i.
load_val_i  input  WIDTH  load value.
conta_o  output  WIDTH  current count.
edge_o  output  1  one-cycle pulse per qualified edge.
tc_o  output  1  terminal count: high while conta_o == MAX_VAL.
ovf_o  output  1  sticky flag: set on any wrap or saturation attempt.

Behaviour:
- Reset (rst_i=1 at a clk edge): the following all go to 0: conta_o, edge_o, ovf_o, the synchroniser flops, the previous-level register and the arm counter. tc_o follows conta_o, so it is 0 unless MAX_VAL==0.
- Priority order: rst_i > clr_i > load_i > count.
- Arming: for SYNC_STAGES+1 cycles after reset release, edge detection is suppressed. During this window the previous-level register still tracks the synchronised level. As a result, an en_i that is already high at reset release is never counted.
- Edge detect: compares the synchronised level s with the previous-level register p, combinationally.
  - Rising: s=1, p=0.
  - Falling: s=0, p=1.
  - Both: s != p.
  - Mode 11: no edges are qualified.
- edge_sel_i changes take effect on the next cycle's detection. There is no pending-edge memory.
- Latency: an en_i transition first sampled at clk edge k updates conta_o and pulses edge_o after edge k+SYNC_STAGES.
- Count, up direction:
  - Below MAX_VAL: +1.
  - At MAX_VAL with SATURATE=0: next value 0, ovf_o set.
  - At MAX_VAL with SATURATE=1: hold MAX_VAL, ovf_o set.
- Count, down direction:
  - Above 0: -1.
  - At 0 with SATURATE=0: next value MAX_VAL, ovf_o set.
  - At 0 with SATURATE=1: hold 0, ovf_o set.
- clr_i: conta_o <= 0 and ovf_o <= 0. A coincident qualified edge is lost, but edge_o still pulses.
- load_i: conta_o <= min(load_val_i, MAX_VAL). ovf_o is unchanged. A coincident edge is not counted, but edge_o still pulses.
- edge_o: registered and asserted for exactly one cycle per qualified edge. It is asserted even under clr/load/saturation. It is suppressed during arming and reset.
- ovf_o: stays set until clr_i or rst_i.
- Arithmetic is WIDTH bits, with explicit compare against MAX_VAL. Values are never truncated silently.

Optional Feature:
CONTADOR_DEBOUNCE_EN
- Defined:
  - A debounce stage is inserted between the synchroniser output and edge detect.
  - The filtered level changes only after the synchronised level has differed from it for DEB_CYCLES consecutive cycles.
  - Any return to the filtered level restarts the run counter at 0.
  - The filtered level and run counter reset to 0.
  - Latency becomes SYNC_STAGES+DEB_CYCLES cycles.
  - The arming window becomes SYNC_STAGES+DEB_CYCLES+1 cycles.
- Undefined: the filtered level equals the synchronised level, DEB_CYCLES is ignored and no debounce logic is generated.

Test Plan:
1. Reset held 5 cycles with en_i=1, released, en_i held high 20 cycles -> conta_o=0, edge_o never asserted, ovf_o=0.
2. Defaults, mode 00, up, 3 clean pulses (en_i high 4 cycles, low 4 cycles) -> conta_o=3. First increment visible exactly 2 edges after en_i first sampled high. 3 single-cycle edge_o pulses.
3. Mode 10, 3 pulses -> conta_o=6. Then mode 11, 2 pulses -> conta_o stays 6, edge_o stays low.
4. WIDTH=4, MAX_VAL=9, SATURATE=0, load 9 (tc_o=1), one rising edge -> conta_o=0, ovf_o=1, tc_o=0. Then up_i=0, one edge -> conta_o=9. Then clr_i -> conta_o=0, ovf_o=0.
5. Same config with SATURATE=1: load 12 -> conta_o=9; 2 edges up -> conta_o=9, ovf_o=1. Qualified edge coinciding with clr_i -> conta_o=0, edge_o=1.
6. CONTADOR_DEBOUNCE_EN, DEB_CYCLES=4: 2-cycle high glitch -> conta_o unchanged. 8-cycle high pulse -> conta_o +1, edge_o after SYNC_STAGES+4 edges.

Source files
------------

// File: rtl/contador_flancos_param.sv
// contador_flancos_param: parametrised edge counter.
// Synchronises the asynchronous event input en_i, detects rising, falling or
// both edges (selectable) and counts them up or down with clear, load, wrap or
// saturate at MAX_VAL, and sticky overflow / terminal-count flags.
// Optional feature macro: CONTADOR_DEBOUNCE_EN inserts a debounce filter of
// DEB_CYCLES stable samples between the synchroniser and the edge detector.
// Handshake: none; every input is sampled on each rising clk edge and
// edge_o is a one-cycle pulse, so consumers simply sample it every cycle.
module contador_flancos_param #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] MAX_VAL     = {WIDTH{1'b1}},
    parameter bit               SATURATE    = 1'b0,
    parameter int unsigned      DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       edge_sel_i,
    input  logic             up_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] conta_o,
    output logic             edge_o,
    output logic             tc_o,
    output logic             ovf_o
);

`ifdef CONTADOR_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    // Edge detection stays blind until the synchroniser (and filter) have
    // flushed whatever they held, so a level present at release is not an edge.
    localparam int unsigned ARM_LEN = SYNC_STAGES + 1 + (DEB_EN ? DEB_CYCLES : 0);
    localparam int unsigned ARM_W   = $clog2(ARM_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   lvl;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_q;
    logic                   armed;
    logic                   raw_edge;
    logic                   qual_edge;
    logic [WIDTH-1:0]       cnt_next;
    logic                   ovf_next;

    // Synchroniser chain: en_i enters at bit 0, the settled level leaves the top.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], en_i};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef CONTADOR_DEBOUNCE_EN
    localparam int unsigned RUN_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    logic [RUN_W-1:0] run_q;
    logic             filt_q;

    // Debounce: adopt the synchronised level only after it has disagreed with
    // the filtered level for DEB_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            run_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync_lvl == filt_q) begin
            run_q <= '0;
        end else if (run_q == RUN_W'(DEB_CYCLES - 1)) begin
            run_q  <= '0;
            filt_q <= sync_lvl;
        end else begin
            run_q <= run_q + RUN_W'(1);
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_lvl;
`endif

    // Previous level and arming counter; the previous level tracks even while unarmed.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            prev_q <= lvl;
            if (!armed) begin
                arm_q <= arm_q + ARM_W'(1);
            end
        end
    end

    assign armed = (arm_q == ARM_W'(ARM_LEN));

    // Edge qualification by mode: 00 rising, 01 falling, 10 both, 11 none.
    always_comb begin
        raw_edge = 1'b0;
        case (edge_sel_i)
            2'b00:   raw_edge = lvl & ~prev_q;
            2'b01:   raw_edge = ~lvl & prev_q;
            2'b10:   raw_edge = lvl ^ prev_q;
            default: raw_edge = 1'b0;
        endcase
    end

    assign qual_edge = raw_edge & armed;

    // Next count and overflow: clear beats load beats counting.
    always_comb begin
        cnt_next = conta_o;
        ovf_next = ovf_o;
        if (clr_i) begin
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (load_i) begin
            cnt_next = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
        end else if (qual_edge) begin
            if (up_i) begin
                if (conta_o >= MAX_VAL) begin
                    cnt_next = SATURATE ? MAX_VAL : '0;
                    ovf_next = 1'b1;
                end else begin
                    cnt_next = conta_o + WIDTH'(1);
                end
            end else begin
                if (conta_o == '0) begin
                    cnt_next = SATURATE ? '0 : MAX_VAL;
                    ovf_next = 1'b1;
                end else begin
                    cnt_next = conta_o - WIDTH'(1);
                end
            end
        end
    end

    // Output registers: count, edge pulse (independent of clr/load) and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            conta_o <= '0;
            edge_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            conta_o <= cnt_next;
            edge_o  <= qual_edge;
            ovf_o   <= ovf_next;
        end
    end

    assign tc_o = (conta_o == MAX_VAL);

endmodule

// File: tb/tb_contador_flancos_param.sv
// Bench for contador_flancos_param: three instances (8-bit default range,
// 4-bit wrapping at 9, 4-bit saturating at 9) share one stimulus stream and are
// compared every cycle with a sample-history reference model, plus a table of
// load/clear vectors and hand-written test-plan sequences.
// Define CONTADOR_DEBOUNCE_EN to exercise the debounce build.
`timescale 1ns/1ps
module tb_contador_flancos_param;
  localparam int SYNC = 2;
`ifdef CONTADOR_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int LAT = SYNC + DEB;
  localparam int ARM_LEN = SYNC + DEB + 1;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, clr, load;
  logic [1:0] edge_sel;
  logic [7:0] load_val;
  logic [7:0] conta_a;
  logic [3:0] conta_b, conta_c;
  logic       edge_a, edge_b, edge_c, tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  contador_flancos_param #(.WIDTH(8), .SYNC_STAGES(SYNC), .SATURATE(1'b0), .DEB_CYCLES(4)) dut_a (
    .clk(clk), .rst_i(rst), .en_i(en), .edge_sel_i(edge_sel), .up_i(up), .clr_i(clr),
    .load_i(load), .load_val_i(load_val), .conta_o(conta_a), .edge_o(edge_a), .tc_o(tc_a), .ovf_o(ovf_a));

  contador_flancos_param #(.WIDTH(4), .SYNC_STAGES(SYNC), .MAX_VAL(4'd9), .SATURATE(1'b0), .DEB_CYCLES(4)) dut_b (
    .clk(clk), .rst_i(rst), .en_i(en), .edge_sel_i(edge_sel), .up_i(up), .clr_i(clr),
    .load_i(load), .load_val_i(load_val[3:0]), .conta_o(conta_b), .edge_o(edge_b), .tc_o(tc_b), .ovf_o(ovf_b));

  contador_flancos_param #(.WIDTH(4), .SYNC_STAGES(SYNC), .MAX_VAL(4'd9), .SATURATE(1'b1), .DEB_CYCLES(4)) dut_c (
    .clk(clk), .rst_i(rst), .en_i(en), .edge_sel_i(edge_sel), .up_i(up), .clr_i(clr),
    .load_i(load), .load_val_i(load_val[3:0]), .conta_o(conta_c), .edge_o(edge_c), .tc_o(tc_c), .ovf_o(ovf_c));

  // scoreboard counters
  int vectors = 0;
  int miscompares = 0;
  int edges_a = 0;

  // reference model state
  int maxv[3] = '{255, 9, 9};
  bit satv[3] = '{1'b0, 1'b0, 1'b1};
  int lwid[3] = '{255, 15, 15};
  int exp_cnt[3];
  bit exp_edge[3];
  bit exp_ovf[3];
  bit en_q[$];   // en_q[i] = en_i sampled at edge i+1 after reset release
  bit lvl_q[$];  // lvl_q[j] = detected level held after edge j
  int n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit en_at(input int idx);
    if (idx >= 1 && idx <= en_q.size()) return en_q[idx-1];
    return 1'b0;
  endfunction

  function automatic bit lvl_at(input int j);
    if (j >= 0 && j < lvl_q.size()) return lvl_q[j];
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit cur, prv, v, all, raw, q, new_lvl;
    int lv;
    if (rst) begin
      n = 0;
      en_q.delete();
      lvl_q.delete();
      lvl_q.push_back(1'b0);
      for (int i = 0; i < 3; i++) begin
        exp_cnt[i] = 0; exp_edge[i] = 1'b0; exp_ovf[i] = 1'b0;
      end
      return;
    end
    n++;
    en_q.push_back(en);
    cur = lvl_at(n - 1);
    prv = lvl_at(n - 2);
    if (DEB == 0) begin
      new_lvl = en_at(n - SYNC + 1);
    end else begin
      // level seen by the filter before this edge, and the last DEB samples
      v = en_at(n - SYNC);
      all = (v != cur);
      for (int j = n - DEB; j <= n - 1; j++)
        if (en_at(j - SYNC + 1) != v) all = 1'b0;
      new_lvl = all ? v : cur;
    end
    lvl_q.push_back(new_lvl);
    case (edge_sel)
      2'b00:   raw = cur && !prv;
      2'b01:   raw = !cur && prv;
      2'b10:   raw = cur != prv;
      default: raw = 1'b0;
    endcase
    q = raw && (n > ARM_LEN);
    for (int i = 0; i < 3; i++) begin
      exp_edge[i] = q;
      lv = int'(load_val) & lwid[i];
      if (clr) begin
        exp_cnt[i] = 0; exp_ovf[i] = 1'b0;
      end else if (load) begin
        exp_cnt[i] = (lv > maxv[i]) ? maxv[i] : lv;
      end else if (q) begin
        if (up) begin
          if (exp_cnt[i] < maxv[i]) exp_cnt[i]++;
          else begin exp_cnt[i] = satv[i] ? maxv[i] : 0; exp_ovf[i] = 1'b1; end
        end else begin
          if (exp_cnt[i] > 0) exp_cnt[i]--;
          else begin exp_cnt[i] = satv[i] ? 0 : maxv[i]; exp_ovf[i] = 1'b1; end
        end
      end
    end
  endtask

  // driver: one clock with full model comparison afterwards
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("conta_a", conta_a, exp_cnt[0]);
    chk("conta_b", conta_b, exp_cnt[1]);
    chk("conta_c", conta_c, exp_cnt[2]);
    chk("edge_a", edge_a, exp_edge[0]);
    chk("edge_b", edge_b, exp_edge[1]);
    chk("edge_c", edge_c, exp_edge[2]);
    chk("tc_a", tc_a, exp_cnt[0] == maxv[0]);
    chk("tc_b", tc_b, exp_cnt[1] == maxv[1]);
    chk("tc_c", tc_c, exp_cnt[2] == maxv[2]);
    chk("ovf_a", ovf_a, exp_ovf[0]);
    chk("ovf_b", ovf_b, exp_ovf[1]);
    chk("ovf_c", ovf_c, exp_ovf[2]);
    if (edge_a) edges_a++;
  endtask

  task automatic pulse(input int hi, input int lo);
    en = 1'b1;
    repeat (hi) cycle();
    en = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic settle();
    en = 1'b0;
    repeat (LAT + 6) cycle();
  endtask

  typedef struct {
    bit         clr;
    bit         load;
    logic [7:0] lv;
    int         exp_a;
    int         exp_b;
    int         exp_c;
    bit         exp_tc_b;
  } vec_t;

  initial begin
    vec_t vt[10];
    int seen, v0, run_left;
    vt[0] = '{1'b1, 1'b0, 8'd0,   0,   0, 0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 8'd5,   5,   5, 5, 1'b0};
    vt[2] = '{1'b0, 1'b1, 8'd12,  12,  9, 9, 1'b1};
    vt[3] = '{1'b0, 1'b1, 8'd15,  15,  9, 9, 1'b1};
    vt[4] = '{1'b0, 1'b1, 8'd0,   0,   0, 0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 8'd9,   0,   0, 0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 8'd3,   3,   3, 3, 1'b0};
    vt[7] = '{1'b0, 1'b0, 8'd0,   3,   3, 3, 1'b0};
    vt[8] = '{1'b0, 1'b1, 8'd9,   9,   9, 9, 1'b1};
    vt[9] = '{1'b0, 1'b1, 8'hFF,  255, 9, 9, 1'b1};

    rst = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0;
    edge_sel = 2'b00; load_val = 8'd0;

    // 1: reset with en high, release, en stays high: nothing counted
    repeat (5) cycle();
    chk("t1_reset_conta", conta_a, 0);
    chk("t1_reset_edge", edge_a, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin cycle(); if (edge_a) seen = 1; end
    chk("t1_no_edge", seen, 0);
    chk("t1_conta", conta_a, 0);
    chk("t1_ovf", ovf_a, 0);

    // 2: rising mode, first-edge latency and three clean pulses
    settle();
    edges_a = 0;
    en = 1'b1;
    cycle();
    for (int i = 1; i < LAT; i++) begin
      cycle();
      chk("t2_lat_early", conta_a, 0);
    end
    cycle();
    chk("t2_lat_conta", conta_a, 1);
    chk("t2_lat_edge", edge_a, 1);
    cycle();
    chk("t2_edge_one_cycle", edge_a, 0);
    en = 1'b0;
    repeat (4) cycle();
    pulse(4, 4);
    pulse(4, 4);
    settle();
    chk("t2_conta", conta_a, 3);
    chk("t2_edges", edges_a, 3);

    // 3: both edges, then disabled mode
    clr = 1'b1; cycle(); clr = 1'b0;
    edge_sel = 2'b10;
    edges_a = 0;
    repeat (3) pulse(4, 4);
    settle();
    chk("t3_both_conta", conta_a, 6);
    chk("t3_both_edges", edges_a, 6);
    edge_sel = 2'b11;
    edges_a = 0;
    repeat (2) pulse(4, 4);
    settle();
    chk("t3_off_conta", conta_a, 6);
    chk("t3_off_edges", edges_a, 0);

    // 4: wrap at MAX_VAL=9 in both directions, then clear
    edge_sel = 2'b00; up = 1'b1;
    load = 1'b1; load_val = 8'd9; cycle(); load = 1'b0;
    chk("t4_tc_loaded", tc_b, 1);
    pulse(8, 8);
    chk("t4_wrap_conta", conta_b, 0);
    chk("t4_wrap_ovf", ovf_b, 1);
    chk("t4_wrap_tc", tc_b, 0);
    chk("t4_sat_conta", conta_c, 9);
    up = 1'b0;
    pulse(8, 8);
    chk("t4_down_wrap", conta_b, 9);
    chk("t4_sat_down", conta_c, 8);
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("t4_clr_conta", conta_b, 0);
    chk("t4_clr_ovf", ovf_b, 0);

    // 5: saturation, clamped load, edge coinciding with clear
    up = 1'b1;
    load = 1'b1; load_val = 8'd12; cycle(); load = 1'b0;
    chk("t5_load_clamp", conta_c, 9);
    pulse(8, 8);
    pulse(8, 8);
    chk("t5_sat_conta", conta_c, 9);
    chk("t5_sat_ovf", ovf_c, 1);
    en = 1'b1;
    cycle();
    repeat (LAT - 1) cycle();
    clr = 1'b1; cycle(); clr = 1'b0;
    chk("t5_clr_edge_conta", conta_c, 0);
    chk("t5_clr_edge_pulse", edge_c, 1);
    settle();

`ifdef CONTADOR_DEBOUNCE_EN
    // 6: short glitch filtered, long pulse counted after SYNC+DEB edges
    v0 = int'(conta_a);
    edges_a = 0;
    pulse(2, 10);
    chk("t6_glitch_conta", conta_a, v0);
    chk("t6_glitch_edges", edges_a, 0);
    en = 1'b1;
    cycle();
    for (int i = 1; i < LAT; i++) begin
      cycle();
      chk("t6_lat_early", edge_a, 0);
    end
    cycle();
    chk("t6_lat_edge", edge_a, 1);
    chk("t6_conta", conta_a, (v0 + 1) % 256);
    cycle();
    settle();
`else
    v0 = 0;
`endif

    // table-driven load/clear vectors with the input held low
    settle();
    foreach (vt[i]) begin
      clr = vt[i].clr; load = vt[i].load; load_val = vt[i].lv;
      cycle();
      chk("tab_conta_a", conta_a, vt[i].exp_a);
      chk("tab_conta_b", conta_b, vt[i].exp_b);
      chk("tab_conta_c", conta_c, vt[i].exp_c);
      chk("tab_tc_b", tc_b, vt[i].exp_tc_b);
    end
    clr = 1'b0; load = 1'b0;

    // randomized stimulus against the reference model
    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        en = ~en;
        run_left = $urandom_range(1, 10);
      end
      run_left--;
      if ($urandom_range(0, 15) == 0) edge_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) up = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 29) == 0);
      load_val = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; clr = 1'b0; load = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
